// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a 7-bit PC through a combinational ROM
// and queues {pc, word} pairs in a two-entry buffer for the consumer.
module fetch_unit (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   output logic [6:0] rom_addr_o,
   input  logic [7:0] rom_data_i,
   input  logic       branch_i,
   input  logic [6:0] branch_target_i,
   output logic [7:0] inst_o,
   output logic [6:0] inst_pc_o,
   output logic       inst_valid_o,
   input  logic       inst_ready_i,
   output logic       halted_o
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t      state, state_next;
   logic [6:0]  pc, pc_next;
   logic [1:0]  count, count_next, count_after_pop;
   logic [14:0] entry0, entry1, entry0_next, entry1_next;
   logic [14:0] new_entry;
   logic        pop, fetch, redirect;

   assign redirect  = branch_i & (state != IDLE);
   assign pop       = inst_valid_o & inst_ready_i;
   assign fetch     = (state == RUN) & ~branch_i & ((count != 2'd2) | pop);
   assign new_entry = {pc, rom_data_i};

   // A pop shifts the tail into the head; a fetch then lands in the first free slot.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      count_next      = count;
      entry0_next     = entry0;
      entry1_next     = entry1;
      count_after_pop = count - {1'b0, pop};
      if (pop) begin
         entry0_next = entry1;
      end
      case (state)
         IDLE: begin
            if (start_i) begin
               state_next = RUN;
            end
         end
         RUN, HALT: begin
            if (redirect) begin
               count_next = 2'd0;
               pc_next    = branch_target_i;
               state_next = RUN;
            end else begin
               count_next = count_after_pop;
               if (fetch) begin
                  if (count_after_pop == 2'd0) begin
                     entry0_next = new_entry;
                  end else begin
                     entry1_next = new_entry;
                  end
                  count_next = count_after_pop + 2'd1;
                  pc_next    = pc + 7'd1;
                  if (rom_data_i == 8'hFF) begin
                     state_next = HALT;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= IDLE;
         pc     <= 7'd0;
         count  <= 2'd0;
         entry0 <= 15'd0;
         entry1 <= 15'd0;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         count  <= count_next;
         entry0 <= entry0_next;
         entry1 <= entry1_next;
      end
   end

   assign rom_addr_o   = pc;
   assign inst_valid_o = (count != 2'd0);
   assign inst_o       = entry0[7:0];
   assign inst_pc_o    = entry0[14:8];
   assign halted_o     = (state == HALT) & (count == 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based model of the fetch/drain/redirect rules.
module tb_fetch_unit;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [6:0] rom_addr_o;
   logic [7:0] rom_data_i;
   logic       branch_i;
   logic [6:0] branch_target_i;
   logic [7:0] inst_o;
   logic [6:0] inst_pc_o;
   logic       inst_valid_o;
   logic       inst_ready_i;
   logic       halted_o;

   logic [7:0] rom [128];

   typedef struct packed {
      logic [6:0] pc;
      logic [7:0] word;
   } item_t;
   typedef enum {M_WAIT, M_FETCH, M_STOPPED} mode_t;

   item_t      model_q[$];
   mode_t      model_mode = M_WAIT;
   logic [6:0] model_pc = 7'd0;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .start_i(start_i),
      .rom_addr_o(rom_addr_o),
      .rom_data_i(rom_data_i),
      .branch_i(branch_i),
      .branch_target_i(branch_target_i),
      .inst_o(inst_o),
      .inst_pc_o(inst_pc_o),
      .inst_valid_o(inst_valid_o),
      .inst_ready_i(inst_ready_i),
      .halted_o(halted_o)
   );

   always #5 clk_i = ~clk_i;
   assign rom_data_i = rom[rom_addr_o];

   task automatic loadCountingRom();
      for (int i = 0; i < 128; i++) rom[i] = (i < 10) ? i[7:0] : 8'hFF;
   endtask

   task automatic loadPlainRom();
      for (int i = 0; i < 128; i++) rom[i] = i[7:0];
   endtask

   // Reference behaviour for one clock edge, evaluated with pre-edge inputs.
   task automatic modelStep(input logic rst, input logic st, input logic br,
                            input logic [6:0] tgt, input logic rdy);
      item_t it;
      if (rst) begin
         model_q.delete();
         model_pc   = 7'd0;
         model_mode = M_WAIT;
      end else if (model_mode == M_WAIT) begin
         if (st) model_mode = M_FETCH;
      end else begin
         if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
         if (br) begin
            model_q.delete();
            model_pc   = tgt;
            model_mode = M_FETCH;
         end else if (model_mode == M_FETCH && model_q.size() < 2) begin
            it.pc   = model_pc;
            it.word = rom[model_pc];
            model_q.push_back(it);
            if (it.word == 8'hFF) model_mode = M_STOPPED;
            model_pc = model_pc + 7'd1;
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic checkOutput();
      checkValue("rom_addr", {1'b0, rom_addr_o}, {1'b0, model_pc});
      checkValue("inst_valid", {7'd0, inst_valid_o}, {7'd0, model_q.size() > 0});
      checkValue("halted", {7'd0, halted_o},
                 {7'd0, (model_mode == M_STOPPED) && (model_q.size() == 0)});
      if (model_q.size() > 0) begin
         checkValue("inst", inst_o, model_q[0].word);
         checkValue("inst_pc", {1'b0, inst_pc_o}, {1'b0, model_q[0].pc});
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic st, input logic br,
                                input logic [6:0] tgt, input logic rdy);
      reset_i         = rst;
      start_i         = st;
      branch_i        = br;
      branch_target_i = tgt;
      inst_ready_i    = rdy;
      modelStep(rst, st, br, tgt, rdy);
      @(posedge clk_i);
      #1;
      checkOutput();
   endtask

   initial begin
      loadCountingRom();
      reset_i = 1'b1; start_i = 1'b0; branch_i = 1'b0;
      branch_target_i = 7'd0; inst_ready_i = 1'b0;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("reset_inst", inst_o, 8'h00);
      checkValue("reset_inst_pc", {1'b0, inst_pc_o}, 8'h00);
      checkValue("reset_valid", {7'd0, inst_valid_o}, 8'h00);
      checkValue("reset_addr", {1'b0, rom_addr_o}, 8'h00);

      // Straight-line run into HALT, then redirect out of HALT
      applyStimulus(0, 1, 0, 0, 1);
      repeat (11) applyStimulus(0, 0, 0, 0, 1);
      checkValue("ff_word", inst_o, 8'hFF);
      checkValue("ff_pc", {1'b0, inst_pc_o}, 8'd10);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("halted_after_ff", {7'd0, halted_o}, 8'd1);
      applyStimulus(0, 0, 1, 7'd3, 1);
      checkValue("halt_exit", {7'd0, halted_o}, 8'd0);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("branch_from_halt", inst_o, 8'h03);

      // Back-pressure saturates the buffer
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 0, 0, 0);
      checkValue("stall_addr", {1'b0, rom_addr_o}, 8'd2);
      checkValue("stall_inst", inst_o, 8'h00);
      repeat (3) applyStimulus(0, 0, 0, 0, 1);

      // Branch flushes queued pcs 1 and 2
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 7'd5, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkValue("flush_inst", inst_o, 8'h05);
      checkValue("flush_pc", {1'b0, inst_pc_o}, 8'd5);
      repeat (3) applyStimulus(0, 0, 0, 0, 1);

      // PC wrap from 127 to 0
      loadPlainRom();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 0, 1, 7'd127, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("wrap_hi", {1'b0, inst_pc_o}, 8'd127);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("wrap_lo", {1'b0, inst_pc_o}, 8'd0);

      // Reset mid-stream with a full buffer, dominant over start and branch
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 7'd40, 0);
      checkValue("midreset_valid", {7'd0, inst_valid_o}, 8'd0);
      checkValue("midreset_addr", {1'b0, rom_addr_o}, 8'd0);
      repeat (3) applyStimulus(0, 0, 0, 0, 1);

      // Random traffic with sparse HALT words
      for (int i = 0; i < 128; i++)
         rom[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      for (int n = 0; n < 800; n++) begin
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0,
                       7'($urandom_range(0, 127)),
                       $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start_i  input  1  leave IDLE and begin fetching.
REQ-004 SHALL have port: rom_addr_o  output  7  instruction ROM address; equals PC register.
REQ-005 SHALL have port: rom_data_i  input  8  ROM word, combinational for rom_addr_o in the same cycle.
REQ-006 SHALL have port: branch_i  input  1  redirect request.
REQ-007 SHALL have port: branch_target_i  input  7  redirect PC.
REQ-008 SHALL have port: inst_o  output  8  instruction at buffer head.
REQ-009 SHALL have port: inst_pc_o  output  7  address of inst_o.
REQ-010 SHALL have port: inst_valid_o  output  1  buffer head valid.
REQ-011 SHALL have port: inst_ready_i  input  1  consumer accepts head.
REQ-012 SHALL have port: halted_o  output  1  HALT state and buffer empty.

Function
REQ-013 SHALL hold a 7-bit PC, 3-state FSM (IDLE, RUN, HALT) and 2-entry FIFO of {pc[6:0], inst[7:0]} with count 0..2.
REQ-014 SHALL drive rom_addr_o from the PC register, never from combinational next-PC.
REQ-015 SHALL define pop = inst_valid_o & inst_ready_i; pop removes the head at the clock edge.
REQ-016 SHALL define fetch = state RUN & !branch_i & (count<2 | pop); on fetch it enqueues {PC, rom_data_i} and PC <= PC+1.
REQ-017 SHALL wrap PC from 127 to 0 on increment.
REQ-018 SHALL make a fetched word visible on inst_o no earlier than one cycle after its address is on rom_addr_o; latency 1 cycle when the FIFO is empty.
REQ-019 SHALL, on fetch with count==2 and pop, keep count at 2 (simultaneous pop/push).
REQ-020 SHALL hold inst_o, inst_pc_o and inst_valid_o stable while inst_valid_o=1 and inst_ready_i=0.
REQ-021 SHALL, in IDLE, do nothing except go to RUN on start_i=1 with PC unchanged; branch_i is ignored in IDLE.
REQ-022 SHALL, in RUN, when a fetch enqueues word 8'hFF, enqueue it, set PC <= PC+1, and enter HALT.
REQ-023 SHALL, in HALT, perform no fetch; FIFO continues to drain by pop.
REQ-024 SHALL, on branch_i=1 in RUN or HALT: the pop of that cycle still completes; all remaining entries are flushed (count <= 0); PC <= branch_target_i; state <= RUN; no fetch that cycle.
REQ-025 SHALL give branch_i priority over a same-cycle 8'hFF fetch (no enqueue, no HALT).
REQ-026 SHALL ignore start_i outside IDLE.
REQ-027 SHALL assert halted_o exactly when state is HALT and count==0.

Reset
REQ-028 SHALL, on reset_i=1 at a clock edge, set state IDLE, PC 0, count 0, regardless of ongoing fetch, pop or branch.
REQ-029 SHALL give reset values: rom_addr_o 0, inst_valid_o 0, halted_o 0, inst_o 8'h00, inst_pc_o 0.
REQ-030 SHALL keep reset dominant over start_i and branch_i in the same cycle.

Verification
REQ-031 SHALL cover: ROM word = address for 0..9, 8'hFF elsewhere; start_i, inst_ready_i=1 -> inst_o 00..09 with inst_pc_o 0..9 on consecutive cycles, then FF at pc 10, halted_o=1 on the cycle after FF is popped.
REQ-032 SHALL cover: inst_ready_i=0 for 5 cycles after start -> count saturates at 2, rom_addr_o stops at 2, inst_o=00 held stable; ready=1 -> 00,01,02 delivered in order without loss.
REQ-033 SHALL cover: branch_i=1, branch_target_i=5 while FIFO holds pcs 1,2 and ready=0 -> next inst_o=05 with inst_pc_o=5, pcs 1,2 never delivered.
REQ-034 SHALL cover: in HALT with FIFO empty, branch_i target 3 -> halted_o drops, inst_o=03 one cycle later.
REQ-035 SHALL cover: PC preset to 127 via branch, all words non-FF -> inst_pc_o 127 then 0 (wrap).
REQ-036 SHALL cover: reset_i asserted mid-stream with count=2 -> next cycle inst_valid_o=0, rom_addr_o=0, state IDLE; no fetch until start_i.
